// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Purpose:
//   Registered, handshaked immediate generator. Each accepted instruction is
//   decoded into its format, its immediate is sign/zero-extended to XLEN, and
//   a PC-relative target is computed for B, J and AUIPC. The decoded bundle
//   appears on the output one cycle after acceptance. A main register plus a
//   one-entry skid register let the upstream stage run at full rate even when
//   the consumer stalls, without a combinational path from out_ready to
//   in_ready.
//
// Parameters:
//   XLEN      datapath width (32 or 64)
//   RV64_OPS  1: OP-IMM-32 (0011011) decodes as I-type; 0: decodes as NONE
//
// Ports:
//   clk         in   1     rising-edge clock
//   rst_n       in   1     asynchronous active-low reset
//   in_valid    in   1     in_inst/in_pc valid
//   in_ready    out  1     block can accept this cycle
//   in_inst     in   32    instruction word
//   in_pc       in   XLEN  address of the instruction
//   out_valid   out  1     output bundle valid
//   out_ready   in   1     consumer accepts the bundle
//   out_imm     out  XLEN  extended immediate
//   out_type    out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
//   out_target  out  XLEN  in_pc + imm for B/J/AUIPC, otherwise 0
//   out_inst    out  32    instruction passed through
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;
  localparam logic [2:0] TYPE_Z    = 3'd6;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // ---------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [31:0]     w_imm32;
  logic [2:0]      w_type;
  logic            w_hasTarget;
  logic [XLEN-1:0] w_immExt;
  logic [XLEN-1:0] w_target;

  assign w_opcode = in_inst[6:0];

  // The immediate is first assembled as a 32-bit value. The CSR zimm is
  // placed with bit 31 clear so the common sign extension below turns into
  // a zero extension for it.
  always_comb begin
    w_imm32     = 32'd0;
    w_type      = TYPE_NONE;
    w_hasTarget = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        w_type  = TYPE_I;
      end
      OP_IMM_32: begin
        if (RV64_OPS) begin
          w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          w_type  = TYPE_I;
        end
      end
      OP_STORE: begin
        w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        w_type  = TYPE_S;
      end
      OP_BRANCH: begin
        w_imm32     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
        w_type      = TYPE_B;
        w_hasTarget = 1'b1;
      end
      OP_LUI: begin
        w_imm32 = {in_inst[31:12], 12'd0};
        w_type  = TYPE_U;
      end
      OP_AUIPC: begin
        w_imm32     = {in_inst[31:12], 12'd0};
        w_type      = TYPE_U;
        w_hasTarget = 1'b1;
      end
      OP_JAL: begin
        w_imm32     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};
        w_type      = TYPE_J;
        w_hasTarget = 1'b1;
      end
      OP_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2] set) carry a zimm.
        if (in_inst[14]) begin
          w_imm32 = {27'd0, in_inst[19:15]};
          w_type  = TYPE_Z;
        end
      end
      default: begin
        w_imm32     = 32'd0;
        w_type      = TYPE_NONE;
        w_hasTarget = 1'b0;
      end
    endcase
  end

  // Sign extension from bit 31 to XLEN (identity when XLEN is 32).
  assign w_immExt = XLEN'($signed(w_imm32));

  // Target wraps modulo 2^XLEN by construction of the XLEN-wide add.
  assign w_target = w_hasTarget ? (in_pc + w_immExt) : '0;

  // ---------------------------------------------------------------------
  // Handshake and two-entry storage
  // ---------------------------------------------------------------------
  logic            r_mainValid;
  logic [XLEN-1:0] r_mainImm;
  logic [2:0]      r_mainType;
  logic [XLEN-1:0] r_mainTarget;
  logic [31:0]     r_mainInst;

  logic            r_skidValid;
  logic [XLEN-1:0] r_skidImm;
  logic [2:0]      r_skidType;
  logic [XLEN-1:0] r_skidTarget;
  logic [31:0]     r_skidInst;

  logic w_accept;
  logic w_consume;

  // in_ready depends only on registered state and the reset pin, so the
  // upstream stage never sees a combinational path from out_ready. The
  // reset term keeps in_ready low for as long as rst_n is held low while
  // still allowing acceptance on the very first edge after release.
  assign in_ready  = rst_n && !r_skidValid;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_mainValid && out_ready;

  // Main register: always holds the oldest bundle. On consume it refills
  // from the skid if that is occupied, otherwise from the input if a new
  // bundle is arriving the same edge, otherwise it empties. Without a
  // consume it only loads when it was empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainValid  <= 1'b0;
      r_mainImm    <= '0;
      r_mainType   <= TYPE_NONE;
      r_mainTarget <= '0;
      r_mainInst   <= '0;
    end else if (w_consume) begin
      if (r_skidValid) begin
        r_mainValid  <= 1'b1;
        r_mainImm    <= r_skidImm;
        r_mainType   <= r_skidType;
        r_mainTarget <= r_skidTarget;
        r_mainInst   <= r_skidInst;
      end else if (w_accept) begin
        r_mainValid  <= 1'b1;
        r_mainImm    <= w_immExt;
        r_mainType   <= w_type;
        r_mainTarget <= w_target;
        r_mainInst   <= in_inst;
      end else begin
        r_mainValid  <= 1'b0;
      end
    end else if (w_accept && !r_mainValid) begin
      r_mainValid  <= 1'b1;
      r_mainImm    <= w_immExt;
      r_mainType   <= w_type;
      r_mainTarget <= w_target;
      r_mainInst   <= in_inst;
    end
  end

  // Skid register: catches a bundle accepted while the main register is
  // full and stalled, and drains into main on the next consume. Because
  // in_ready is low while the skid is full, it can never be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skidValid  <= 1'b0;
      r_skidImm    <= '0;
      r_skidType   <= TYPE_NONE;
      r_skidTarget <= '0;
      r_skidInst   <= '0;
    end else if (w_consume && r_skidValid) begin
      r_skidValid  <= 1'b0;
    end else if (w_accept && r_mainValid && !w_consume) begin
      r_skidValid  <= 1'b1;
      r_skidImm    <= w_immExt;
      r_skidType   <= w_type;
      r_skidTarget <= w_target;
      r_skidInst   <= in_inst;
    end
  end

  assign out_valid  = r_mainValid;
  assign out_imm    = r_mainImm;
  assign out_type   = r_mainType;
  assign out_target = r_mainTarget;
  assign out_inst   = r_mainInst;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Purpose:
//   Self-checking bench for imm_gen_pipe. One instance runs at XLEN=32 with
//   RV64_OPS=0, a second at XLEN=64 with RV64_OPS=1. Drivers push the
//   expected bundle into a per-instance queue at the edge where the DUT
//   accepts; independent monitors pop and compare whenever a bundle is
//   transferred on the output side.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] target;
    logic [31:0] inst;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        inValid32, inReady32, outValid32, outReady32;
  logic [31:0] inInst32, inPc32, outImm32, outTarget32, outInst32;
  logic [2:0]  outType32;

  logic        inValid64, inReady64, outValid64, outReady64;
  logic [31:0] inInst64, outInst64;
  logic [63:0] inPc64, outImm64, outTarget64;
  logic [2:0]  outType64;

  bundle_t q32[$];
  bundle_t q64[$];
  int      testsRun    = 0;
  int      testsFailed = 0;
  int      sinkMode    = 0;   // 0 always ready, 1 stalled, 2 random

  imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid32), .in_ready(inReady32),
    .in_inst(inInst32), .in_pc(inPc32),
    .out_valid(outValid32), .out_ready(outReady32),
    .out_imm(outImm32), .out_type(outType32),
    .out_target(outTarget32), .out_inst(outInst32)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid64), .in_ready(inReady64),
    .in_inst(inInst64), .in_pc(inPc64),
    .out_valid(outValid64), .out_ready(outReady64),
    .out_imm(outImm64), .out_type(outType64),
    .out_target(outTarget64), .out_inst(outInst64)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [63:0] imm, input logic [2:0] typ,
                                 input logic [63:0] target, input logic [31:0] inst);
    bundle_t b;
    b.imm = imm; b.typ = typ; b.target = target; b.inst = inst;
    return b;
  endfunction

  // Reference decode for the XLEN=32, RV64_OPS=0 instance.
  function automatic bundle_t model32(input logic [31:0] inst, input logic [31:0] pc);
    logic [31:0] imm;
    logic [2:0]  t;
    logic        hasT;
    imm = 32'd0; t = 3'd0; hasT = 1'b0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67: begin t = 3'd1; imm = {{20{inst[31]}}, inst[31:20]}; end
      7'h23: begin t = 3'd2; imm = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
      7'h63: begin
        t = 3'd3; hasT = 1'b1;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'h37: begin t = 3'd4; imm = {inst[31:12], 12'd0}; end
      7'h17: begin t = 3'd4; hasT = 1'b1; imm = {inst[31:12], 12'd0}; end
      7'h6F: begin
        t = 3'd5; hasT = 1'b1;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'h73: if (inst[14]) begin t = 3'd6; imm = {27'd0, inst[19:15]}; end
      default: begin imm = 32'd0; t = 3'd0; end
    endcase
    return mk({32'd0, imm}, t, hasT ? {32'd0, pc + imm} : 64'd0, inst);
  endfunction

  // Drive one instruction into the 32-bit instance and hold it until taken.
  // in_ready is sampled mid-cycle; it only changes on clock edges or reset.
  task automatic applyStimulus32(input logic [31:0] inst, input logic [31:0] pc,
                                 input bundle_t exp);
    bit accepted = 0;
    bit rdy;
    @(negedge clk);
    inValid32 = 1'b1; inInst32 = inst; inPc32 = pc;
    for (int c = 0; c < 200 && !accepted; c++) begin
      #1 rdy = inReady32;
      @(posedge clk);
      if (rdy) begin
        q32.push_back(exp);
        accepted = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) begin
      checkOutput("accept_timeout32", 64'd0, 64'd1);
      inValid32 = 1'b0;
    end
  endtask

  task automatic applyStimulus64(input logic [31:0] inst, input logic [63:0] pc,
                                 input bundle_t exp);
    bit accepted = 0;
    bit rdy;
    @(negedge clk);
    inValid64 = 1'b1; inInst64 = inst; inPc64 = pc;
    for (int c = 0; c < 200 && !accepted; c++) begin
      #1 rdy = inReady64;
      @(posedge clk);
      if (rdy) begin
        q64.push_back(exp);
        accepted = 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    inValid64 = 1'b0;
    if (!accepted) checkOutput("accept_timeout64", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && (q32.size() > 0 || q64.size() > 0); c++)
      @(posedge clk);
    if (q32.size() > 0 || q64.size() > 0)
      checkOutput("drain_timeout", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  // Monitor / sink for the 32-bit instance. Also checks that a stalled
  // bundle stays put until it is taken.
  initial begin
    bundle_t     e;
    bit          prevStall = 0;
    logic [31:0] prevInst  = '0;
    outReady32 = 1'b0;
    forever begin
      @(negedge clk);
      case (sinkMode)
        0:       outReady32 = 1'b1;
        1:       outReady32 = 1'b0;
        default: outReady32 = ($urandom_range(0, 3) != 0);
      endcase
      #2;
      if (rst_n && prevStall)
        checkOutput("hold32", {31'd0, outValid32, outInst32}, {31'd0, 1'b1, prevInst});
      if (rst_n && outValid32 && outReady32) begin
        if (q32.size() == 0) begin
          checkOutput("unexpected32", {32'd0, outInst32}, 64'hDEAD);
        end else begin
          e = q32.pop_front();
          checkOutput("inst32",   {32'd0, outInst32},   {32'd0, e.inst});
          checkOutput("type32",   {61'd0, outType32},   {61'd0, e.typ});
          checkOutput("imm32",    {32'd0, outImm32},    e.imm);
          checkOutput("target32", {32'd0, outTarget32}, e.target);
        end
      end
      prevStall = rst_n && outValid32 && !outReady32;
      prevInst  = outInst32;
    end
  end

  // Monitor for the 64-bit instance, which is never stalled.
  initial begin
    bundle_t e;
    outReady64 = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && outValid64) begin
        if (q64.size() == 0) begin
          checkOutput("unexpected64", {32'd0, outInst64}, 64'hDEAD);
        end else begin
          e = q64.pop_front();
          checkOutput("inst64",   {32'd0, outInst64}, {32'd0, e.inst});
          checkOutput("type64",   {61'd0, outType64}, {61'd0, e.typ});
          checkOutput("imm64",    outImm64,           e.imm);
          checkOutput("target64", outTarget64,        e.target);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence
  initial begin
    logic [6:0]  ops [12];
    logic [31:0] rInst, rPc;
    int unsigned r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h73, 7'h1B, 7'h0F, 7'h33};

    rst_n = 1'b0;
    inValid32 = 1'b0; inInst32 = '0; inPc32 = '0;
    inValid64 = 1'b0; inInst64 = '0; inPc64 = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", {63'd0, outValid32}, 64'd0);
    checkOutput("rst_in_ready",  {63'd0, inReady32},  64'd0);
    checkOutput("rst_out_imm",   {32'd0, outImm32},   64'd0);
    checkOutput("rst_out_inst",  {32'd0, outInst32},  64'd0);
    checkOutput("rst_out_type",  {61'd0, outType32},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel_in_ready", {63'd0, inReady32}, 64'd1);

    // Directed decode, 32-bit instance
    applyStimulus32(32'hFFF00093, 32'h100, mk(64'hFFFFFFFF, 3'd1, 64'd0,     32'hFFF00093));
    applyStimulus32(32'hFE000EE3, 32'h200, mk(64'hFFFFFFFC, 3'd3, 64'h1FC,   32'hFE000EE3));
    applyStimulus32(32'hFE112E23, 32'h204, mk(64'hFFFFFFFC, 3'd2, 64'd0,     32'hFE112E23));
    applyStimulus32(32'h0080006F, 32'h300, mk(64'd8,        3'd5, 64'h308,   32'h0080006F));
    applyStimulus32(32'h00C08067, 32'h304, mk(64'd12,       3'd1, 64'd0,     32'h00C08067));
    applyStimulus32(32'h800000B7, 32'h308, mk(64'h80000000, 3'd4, 64'd0,     32'h800000B7));
    applyStimulus32(32'h00001097, 32'h1000, mk(64'h1000,    3'd4, 64'h2000,  32'h00001097));
    applyStimulus32(32'h0010009B, 32'h400, mk(64'd0,        3'd0, 64'd0,     32'h0010009B));
    applyStimulus32(32'h0FF7D073, 32'h404, mk(64'd15,       3'd6, 64'd0,     32'h0FF7D073));
    applyStimulus32(32'h34011073, 32'h408, mk(64'd0,        3'd0, 64'd0,     32'h34011073));
    applyStimulus32(32'h0FF0000F, 32'h40C, mk(64'd0,        3'd0, 64'd0,     32'h0FF0000F));
    applyStimulus32(32'hFFDFF06F, 32'h10, mk(64'hFFFFFFFC,  3'd5, 64'hC,     32'hFFDFF06F));
    applyStimulus32(32'hFE000EE3, 32'h2,  mk(64'hFFFFFFFC,  3'd3, 64'hFFFFFFFE, 32'hFE000EE3));
    @(negedge clk);
    inValid32 = 1'b0;

    // Directed decode, 64-bit instance
    applyStimulus64(32'h800000B7, 64'h0,    mk(64'hFFFFFFFF80000000, 3'd4, 64'd0,    32'h800000B7));
    applyStimulus64(32'h00001097, 64'h1000, mk(64'h1000,             3'd4, 64'h2000, 32'h00001097));
    applyStimulus64(32'hFE000EE3, 64'h200,  mk(64'hFFFFFFFFFFFFFFFC, 3'd3, 64'h1FC,  32'hFE000EE3));
    applyStimulus64(32'h0010009B, 64'h0,    mk(64'd1,                3'd1, 64'd0,    32'h0010009B));
    applyStimulus64(32'h0FF7D073, 64'h0,    mk(64'd15,               3'd6, 64'd0,    32'h0FF7D073));
    drain();

    // Backpressure: A and B captured, C waits until the stall releases.
    @(posedge clk);
    sinkMode = 1;
    applyStimulus32(32'h00100093, 32'h0, mk(64'd1, 3'd1, 64'd0, 32'h00100093));
    applyStimulus32(32'h00200093, 32'h0, mk(64'd2, 3'd1, 64'd0, 32'h00200093));
    fork
      applyStimulus32(32'h00300093, 32'h0, mk(64'd3, 3'd1, 64'd0, 32'h00300093));
    join_none
    @(negedge clk);
    #1;
    checkOutput("bp_in_ready",  {63'd0, inReady32},  64'd0);
    checkOutput("bp_out_valid", {63'd0, outValid32}, 64'd1);
    checkOutput("bp_out_inst",  {32'd0, outInst32},  64'h00100093);
    repeat (2) @(posedge clk);
    sinkMode = 0;
    wait fork;
    @(negedge clk);
    inValid32 = 1'b0;
    drain();

    // Reset with both entries occupied discards them at once.
    @(posedge clk);
    sinkMode = 1;
    applyStimulus32(32'h00400093, 32'h0, mk(64'd4, 3'd1, 64'd0, 32'h00400093));
    applyStimulus32(32'h00500093, 32'h0, mk(64'd5, 3'd1, 64'd0, 32'h00500093));
    @(negedge clk);
    inValid32 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {63'd0, outValid32}, 64'd0);
    checkOutput("mid_rst_in_ready",  {63'd0, inReady32},  64'd0);
    checkOutput("mid_rst_out_inst",  {32'd0, outInst32},  64'd0);
    q32.delete();
    q64.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("post_rst_in_ready", {63'd0, inReady32}, 64'd1);
    @(posedge clk);
    sinkMode = 0;
    applyStimulus32(32'h00600093, 32'h0, mk(64'd6, 3'd1, 64'd0, 32'h00600093));
    @(negedge clk);
    inValid32 = 1'b0;
    drain();

    // Random stream against the reference model.
    @(posedge clk);
    sinkMode = 2;
    for (int n = 0; n < 10000; n++) begin
      r     = $urandom();
      rInst = {r[31:7], ops[$urandom_range(0, 11)]};
      rPc   = $urandom() & 32'hFFFFFFFC;
      applyStimulus32(rInst, rPc, model32(rInst, rPc));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        inValid32 = 1'b0;
      end
    end
    @(negedge clk);
    inValid32 = 1'b0;
    @(posedge clk);
    sinkMode = 0;
    drain();

    checkOutput("queues_empty", 64'(q32.size() + q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
